spram_data_mem_ctrl: RTL and testbench

- Parametrised 32-bit data-memory controller built from iCE40 SB_SPRAM256KA primitives, cascaded in width (2 per bank) and depth (NUM_BANKS).
- Adds a valid/ready request handshake, byte-enable stores, a registered read response, and a power FSM: auto-standby after idle, software sleep, timed wake.
- Sits between the processor load/store unit and the SPRAM macros, replacing the fixed single-bank data memory.

---
 rtl/spram_mem_pkg.sv | 20 ++
 rtl/SB_SPRAM256KA.sv | 33 +++
 rtl/spram_bank_32.sv | 54 +++++
 rtl/spram_data_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spram_data_mem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_mem_pkg.sv
// Shared types and helpers for the SPRAM-based data-memory controller.
package spram_mem_pkg;

  // Power-state encoding, also exported on the pwr_state port.
  typedef enum logic [1:0] {
    PWR_ACTIVE  = 2'd0,
    PWR_STANDBY = 2'd1,
    PWR_SLEEP   = 2'd2,
    PWR_WAKE    = 2'd3
  } pwr_state_e;

  // Row address width of one SB_SPRAM256KA (16K entries).
  localparam int unsigned SPRAM_ROW_W = 14;

  // The SPRAM write mask has one bit per nibble, so each byte enable covers two mask bits.
  function automatic logic [3:0] be_to_nibble_mask(input logic [1:0] be);
    return {be[1], be[1], be[0], be[0]};
  endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40 UP SPRAM cell (16K x 16, nibble write mask).
// Keep this file out of the iCE40 build, where the vendor cell is used instead.
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [16384];

  // Masked write or registered read; no access while in a low-power mode.
  always_ff @(posedge CLOCK) begin
    if (CHIPSELECT && !STANDBY && !SLEEP && POWEROFF) begin
      if (WREN) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWREN[i]) begin
            mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
          end
        end
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end

endmodule

// File: rtl/spram_bank_32.sv
// One 16K x 32 bank built from two SPRAM cells side by side (bits 31:16 and 15:0).
module spram_bank_32
  import spram_mem_pkg::*;
(
  input  logic                   clk_i,
  input  logic [SPRAM_ROW_W-1:0] addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             be_i,
  input  logic                   we_i,
  input  logic                   cs_i,
  input  logic                   standby_i,
  input  logic                   sleep_i,
  output logic [31:0]            rdata_o
);

  logic [3:0]  mask_hi;
  logic [3:0]  mask_lo;
  logic [15:0] rdata_hi;
  logic [15:0] rdata_lo;

  // Split the byte enables into per-cell nibble masks.
  always_comb begin
    mask_hi = be_to_nibble_mask(be_i[3:2]);
    mask_lo = be_to_nibble_mask(be_i[1:0]);
    rdata_o = {rdata_hi, rdata_lo};
  end

  SB_SPRAM256KA u_spram_hi (
    .ADDRESS    (addr_i),
    .DATAIN     (wdata_i[31:16]),
    .MASKWREN   (mask_hi),
    .WREN       (we_i),
    .CHIPSELECT (cs_i),
    .CLOCK      (clk_i),
    .STANDBY    (standby_i),
    .SLEEP      (sleep_i),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata_hi)
  );

  SB_SPRAM256KA u_spram_lo (
    .ADDRESS    (addr_i),
    .DATAIN     (wdata_i[15:0]),
    .MASKWREN   (mask_lo),
    .WREN       (we_i),
    .CHIPSELECT (cs_i),
    .CLOCK      (clk_i),
    .STANDBY    (standby_i),
    .SLEEP      (sleep_i),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata_lo)
  );

endmodule

// File: rtl/spram_data_mem_ctrl.sv
// 32-bit data-memory controller over NUM_BANKS SPRAM banks: valid/ready requests,
// byte-enable stores, registered load response and an ACTIVE/STANDBY/SLEEP/WAKE power FSM.
module spram_data_mem_ctrl
  import spram_mem_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 2,
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  localparam int unsigned ADDR_W = SPRAM_ROW_W + BANK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  input  logic              sleep_req,
  output logic [1:0]        pwr_state
);

  localparam int unsigned BANK_IDX_W = (BANK_W > 0) ? BANK_W : 1;
  localparam int unsigned IDLE_CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned WAKE_CNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST =
      IDLE_CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST =
      WAKE_CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  pwr_state_e            state_q;
  logic [IDLE_CNT_W-1:0] idle_cnt_q;
  logic [WAKE_CNT_W-1:0] wake_cnt_q;
  logic                  standby_q;
  logic                  sleep_q;

  logic                  accept;
  logic                  ld_accept;
  logic                  idle_hit;
  logic [BANK_IDX_W-1:0] bank_sel;
  logic [BANK_IDX_W-1:0] bank_q;
  logic [NUM_BANKS-1:0]  bank_cs;
  logic [31:0]           bank_rdata [NUM_BANKS];
  logic                  rsp_valid_q;
  logic [31:0]           rdata_hold_q;

  if (BANK_W > 0) begin : g_bank_sel
    assign bank_sel = req_addr[ADDR_W-1:SPRAM_ROW_W];
  end else begin : g_single_bank
    assign bank_sel = '0;
  end

  // Handshake: only ACTIVE accepts, and a sleep request blocks new traffic immediately.
  always_comb begin
    req_ready = (state_q == PWR_ACTIVE) && !sleep_req && !reset;
    accept    = req_valid && req_ready;
    ld_accept = accept && !req_we;
    idle_hit  = (IDLE_CYCLES != 0) && (idle_cnt_q == IDLE_LAST);
  end

  // Chip-select only the addressed bank, and only on the accept cycle.
  always_comb begin
    bank_cs = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_cs[b] = accept && (bank_sel == BANK_IDX_W'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spram_bank_32 u_bank (
      .clk_i     (clk),
      .addr_i    (req_addr[SPRAM_ROW_W-1:0]),
      .wdata_i   (req_wdata),
      .be_i      (req_be),
      .we_i      (req_we),
      .cs_i      (bank_cs[b]),
      .standby_i (standby_q),
      .sleep_i   (sleep_q),
      .rdata_o   (bank_rdata[b])
    );
  end

  // Load response: pulse one cycle after accept and remember which bank to return.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      bank_q       <= '0;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid_q <= ld_accept;
      if (ld_accept) begin
        bank_q <= bank_sel;
      end
      if (rsp_valid_q) begin
        rdata_hold_q <= bank_rdata[bank_q];
      end
    end
  end

  // SPRAM output can change on later accesses or in low power, so hold the last load here.
  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_valid_q ? bank_rdata[bank_q] : rdata_hold_q;
    pwr_state = state_q;
  end

  // Power FSM; SPRAM STANDBY/SLEEP pins are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PWR_ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      standby_q  <= 1'b0;
      sleep_q    <= 1'b0;
    end else begin
      unique case (state_q)
        PWR_ACTIVE: begin
          // A load accepted this cycle is read before the cells go to sleep.
          if (sleep_req && !ld_accept) begin
            state_q    <= PWR_SLEEP;
            sleep_q    <= 1'b1;
            idle_cnt_q <= '0;
          end else if (accept) begin
            idle_cnt_q <= '0;
          end else if (idle_hit) begin
            state_q    <= PWR_STANDBY;
            standby_q  <= 1'b1;
            idle_cnt_q <= '0;
          end else if (IDLE_CYCLES != 0) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        PWR_STANDBY: begin
          if (sleep_req) begin
            state_q   <= PWR_SLEEP;
            standby_q <= 1'b0;
            sleep_q   <= 1'b1;
          end else if (req_valid) begin
            state_q    <= PWR_WAKE;
            standby_q  <= 1'b0;
            wake_cnt_q <= '0;
          end
        end
        PWR_SLEEP: begin
          if (!sleep_req) begin
            state_q    <= PWR_WAKE;
            sleep_q    <= 1'b0;
            wake_cnt_q <= '0;
          end
        end
        PWR_WAKE: begin
          if (sleep_req) begin
            state_q <= PWR_SLEEP;
            sleep_q <= 1'b1;
          end else if (wake_cnt_q == WAKE_LAST) begin
            state_q    <= PWR_ACTIVE;
            idle_cnt_q <= '0;
          end else begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spram_data_mem_ctrl.sv
// Self-checking bench for spram_data_mem_ctrl with a word-level memory model.
module tb_spram_data_mem_ctrl;

  localparam int unsigned IDLE = 4;
  localparam int unsigned AW   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          sleep_req;
  logic [1:0]    pwr_state;

  int n_vec = 0;
  int n_err = 0;

  // Expected memory contents, word address -> data.
  logic [31:0] model [int];

  always #5 clk = ~clk;

  spram_data_mem_ctrl #(
    .NUM_BANKS   (2),
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sleep_req (sleep_req),
    .pwr_state (pwr_state)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Drive one request, wait for acceptance, then check the cycle after accept.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string name, output int waited);
    logic [31:0] exp_data;
    logic [1:0]  exp_cs;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    waited    = 0;
    @(negedge clk);
    while (!req_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: req_ready=%b, required 1 within 60 cycles", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    exp_cs = 2'b01 << addr[AW-1];
    n_vec++;
    if (dut.bank_cs !== exp_cs) begin
      n_err++;
      $display("FAIL %s chipselect: got %b, required %b", name, dut.bank_cs, exp_cs);
    end
    exp_data = model.exists(int'(addr)) ? model[int'(addr)] : 32'h0;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) exp_data[8*i +: 8] = wdata[8*i +: 8];
      end
      model[int'(addr)] = exp_data;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== ~we) begin
      n_err++;
      $display("FAIL %s rsp_valid: got %b, required %b", name, rsp_valid, ~we);
    end
    if (!we) begin
      n_vec++;
      if (rsp_rdata !== exp_data) begin
        n_err++;
        $display("FAIL %s rsp_rdata: got %h, required %h", name, rsp_rdata, exp_data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pwr(input logic [1:0] exp, input string name);
    n_vec++;
    if (pwr_state !== exp) begin
      n_err++;
      $display("FAIL %s pwr_state: got %0d, required %0d", name, pwr_state, exp);
    end
  endtask

  task automatic expect_ready(input logic exp, input string name);
    n_vec++;
    if (req_ready !== exp) begin
      n_err++;
      $display("FAIL %s req_ready: got %b, required %b", name, req_ready, exp);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    sleep_req = 1'b0;
    repeat (3) tick();
    expect_pwr(2'd0, "reset");
    expect_ready(1'b0, "reset_ready_low");
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset rsp: got valid=%b data=%h, required 0/0", rsp_valid, rsp_rdata);
    end
    reset = 1'b0;
    #1;
    expect_ready(1'b1, "reset_release_ready");
  endtask

  task automatic test_byte_enables();
    int w;
    issue(1'b1, 15'h0005, 32'hDEADBEEF, 4'hF, "be_full_store", w);
    issue(1'b0, 15'h0005, 32'h0, 4'h0, "be_full_load", w);
    n_vec++;
    if (rsp_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL be_full_const: got %h, required DEADBEEF", rsp_rdata);
    end
    issue(1'b1, 15'h0005, 32'h11223344, 4'b0101, "be_partial_store", w);
    issue(1'b0, 15'h0005, 32'h0, 4'h0, "be_partial_load", w);
    n_vec++;
    if (rsp_rdata !== 32'hDE22BE44) begin
      n_err++;
      $display("FAIL be_partial_const: got %h, required DE22BE44", rsp_rdata);
    end
    issue(1'b1, 15'h0005, 32'h55555555, 4'h0, "be_zero_store", w);
    issue(1'b0, 15'h0005, 32'h0, 4'h0, "be_zero_load", w);
    n_vec++;
    if (rsp_rdata !== 32'hDE22BE44) begin
      n_err++;
      $display("FAIL be_zero_const: got %h, required DE22BE44", rsp_rdata);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w;
    issue(1'b1, 15'h0010, 32'h0000000A, 4'hF, "b2b_store_bank0", w);
    issue(1'b1, 15'h4010, 32'h0000000B, 4'hF, "b2b_store_bank1", w);
    issue(1'b0, 15'h0010, 32'h0, 4'h0, "b2b_load_bank0", w);
    n_vec++;
    if (rsp_rdata !== 32'h0000000A) begin
      n_err++;
      $display("FAIL b2b_first_const: got %h, required 0000000A", rsp_rdata);
    end
    issue(1'b0, 15'h4010, 32'h0, 4'h0, "b2b_load_bank1", w);
    n_vec++;
    if (w != 0 || rsp_rdata !== 32'h0000000B) begin
      n_err++;
      $display("FAIL b2b_second: wait=%0d data=%h, required 0/0000000B", w, rsp_rdata);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_standby_wake();
    int w;
    issue(1'b1, 15'h0020, 32'hCAFEF00D, 4'hF, "stby_store", w);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_pwr(2'd0, "stby_still_active");
    end
    tick();
    expect_pwr(2'd1, "stby_entered");
    tick();
    expect_pwr(2'd1, "stby_held");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 15'h0005;
    #1;
    expect_ready(1'b0, "stby_not_ready");
    tick();
    expect_pwr(2'd3, "stby_wake1");
    tick();
    expect_pwr(2'd3, "stby_wake2");
    tick();
    expect_pwr(2'd0, "stby_active");
    expect_ready(1'b1, "stby_ready");
    tick();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model[5]) begin
      n_err++;
      $display("FAIL stby_load: valid=%b data=%h, required 1/%h", rsp_valid, rsp_rdata, model[5]);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_sleep();
    int w;
    issue(1'b0, 15'h0005, 32'h0, 4'h0, "sleep_load", w);
    sleep_req = 1'b1;
    req_valid = 1'b0;
    #1;
    expect_pwr(2'd0, "sleep_resp_cycle");
    expect_ready(1'b0, "sleep_blocks_ready");
    tick();
    expect_pwr(2'd2, "sleep_entered");
    repeat (3) tick();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 15'h4010;
    #1;
    expect_ready(1'b0, "sleep_not_ready");
    tick();
    expect_pwr(2'd2, "sleep_held");
    sleep_req = 1'b0;
    tick();
    expect_pwr(2'd3, "sleep_wake1");
    tick();
    expect_pwr(2'd3, "sleep_wake2");
    tick();
    expect_pwr(2'd0, "sleep_active");
    tick();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000000B) begin
      n_err++;
      $display("FAIL sleep_retained: valid=%b data=%h, required 1/0000000B", rsp_valid, rsp_rdata);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_in_wake();
    int n;
    sleep_req = 1'b1;
    n = 0;
    tick();
    while (pwr_state !== 2'd2 && n < 10) begin
      tick();
      n++;
    end
    expect_pwr(2'd2, "rstwake_sleep");
    sleep_req = 1'b0;
    tick();
    expect_pwr(2'd3, "rstwake_in_wake");
    reset = 1'b1;
    tick();
    expect_pwr(2'd0, "rstwake_active");
    expect_ready(1'b0, "rstwake_ready_low");
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstwake_rsp_valid: got %b, required 0", rsp_valid);
    end
    reset = 1'b0;
    #1;
    expect_ready(1'b1, "rstwake_ready_high");
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [16];
    int w;
    int g;
    for (int i = 0; i < 16; i++) begin
      pool[i] = AW'(((i % 2) << 14) | $urandom_range(0, 16383));
      issue(1'b1, pool[i], $urandom, 4'hF, "rand_fill", w);
    end
    for (int k = 0; k < 250; k++) begin
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], $urandom,
            4'($urandom_range(0, 15)), "rand_op", w);
      if ($urandom_range(0, 7) == 0) begin
        req_valid = 1'b0;
        g = $urandom_range(1, 8);
        repeat (g) tick();
        expect_pwr((g >= IDLE) ? 2'd1 : 2'd0, "rand_gap_state");
      end
      if ($urandom_range(0, 19) == 0) begin
        req_valid = 1'b0;
        sleep_req = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        expect_pwr(2'd2, "rand_sleep_state");
        sleep_req = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_enables();
    test_back_to_back();
    test_standby_wake();
    test_sleep();
    test_reset_in_wake();
    test_random();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
